// File: rtl/ds2_pkg.sv
// ds2_pkg: shared definitions for the DualShock poll scheduler.
//   state_t      scheduler FSM states
//   CMD_*        command bytes sent in each frame
//   ID_*         upper ID nibbles accepted as a valid pad
//   BTN_*        bit positions inside the 12-bit button word
//   map_buttons  active-low b0/b1 words -> active-high 12-bit word
//   tx_byte      command byte for a given frame byte index
package ds2_pkg;

  typedef enum logic [2:0] {IDLE, SEL, XFER, GAP, DESEL, NEXT} state_t;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;
  localparam logic [7:0] CMD_IDLE  = 8'h00;

  localparam logic [3:0] ID_DIGITAL = 4'h4;
  localparam logic [3:0] ID_ANALOG  = 4'h7;

  localparam int BTN_R      = 11;
  localparam int BTN_L      = 10;
  localparam int BTN_X      = 9;
  localparam int BTN_A      = 8;
  localparam int BTN_RT     = 7;
  localparam int BTN_LT     = 6;
  localparam int BTN_DN     = 5;
  localparam int BTN_UP     = 4;
  localparam int BTN_START  = 3;
  localparam int BTN_SELECT = 2;
  localparam int BTN_Y      = 1;
  localparam int BTN_B      = 0;

  function automatic logic [11:0] map_buttons(input logic [7:0] b0, input logic [7:0] b1);
    logic [11:0] w;
    w             = '0;
    // R/L merge the two shoulder buttons on each side
    w[BTN_R]      = ~b1[3] | ~b1[1];
    w[BTN_L]      = ~b1[2] | ~b1[0];
    w[BTN_X]      = ~b1[4];
    w[BTN_A]      = ~b1[5];
    w[BTN_RT]     = ~b0[5];
    w[BTN_LT]     = ~b0[7];
    w[BTN_DN]     = ~b0[6];
    w[BTN_UP]     = ~b0[4];
    w[BTN_START]  = ~b0[3];
    w[BTN_SELECT] = ~b0[0];
    w[BTN_Y]      = ~b1[7];
    w[BTN_B]      = ~b1[6];
    return w;
  endfunction

  function automatic logic [7:0] tx_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_START;
      3'd1:    return CMD_POLL;
      default: return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ds2_spi_byte.sv
// ds2_spi_byte: single-byte shift engine, LSB first, clock idle high.
//   clk, rst_n   system clock, async active-low reset
//   hp           half-period strobe from the scheduler
//   start        begin a byte (honoured only while idle); first fall happens on this edge
//   tx / rx      byte to send / byte received (valid while done is high)
//   miso         already-synchronized data in
//   sck, mosi    bus outputs
//   done         high on the half-period edge that ends the 8th high phase
module ds2_spi_byte (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hp,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx
);
  logic       busy;
  logic       phase;  // 0: clock low half, 1: clock high half
  logic [2:0] bitn;

  assign done = busy && hp && phase && (bitn == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      phase <= 1'b0;
      bitn  <= 3'd0;
      sck   <= 1'b1;
      mosi  <= 1'b1;
      rx    <= 8'h00;
    end else if (!busy) begin
      if (start) begin
        busy  <= 1'b1;
        phase <= 1'b0;
        bitn  <= 3'd0;
        sck   <= 1'b0;
        mosi  <= tx[0];
      end
    end else if (hp) begin
      if (!phase) begin
        sck   <= 1'b1;
        rx    <= {miso, rx[7:1]};
        phase <= 1'b1;
      end else if (bitn == 3'd7) begin
        busy  <= 1'b0;
        mosi  <= 1'b1;
      end else begin
        bitn  <= bitn + 3'd1;
        sck   <= 1'b0;
        mosi  <= tx[bitn + 3'd1];
        phase <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ds2_poll_scheduler.sv
// ds2_poll_scheduler: polls one or two DualShock pads over a shared bus.
//   clk, I_RSTn            system clock, async active-low reset
//   ds_clk/ds_mosi/ds_miso shared serial bus (clock idle high)
//   ds_cs[1:0]             per-port select, active-low (bit0 = port 1)
//   p1/p2_buttons          latched button words, active-high
//   p1/p2_connected        port currently holds a valid pad
//   frame_done             one-cycle pulse at end of each port frame
// Build macro DS2_PORT2_EN enables port 2; without it only port 1 is polled
// and the port-2 outputs are constant.
module ds2_poll_scheduler
  import ds2_pkg::*;
#(
  parameter int FREQ    = 21_600_000,
  parameter int SCK_HZ  = 250_000,
  parameter int POLL_HZ = 60
) (
  input  logic        clk,
  input  logic        I_RSTn,
  output logic        ds_clk,
  output logic        ds_mosi,
  input  logic        ds_miso,
  output logic [1:0]  ds_cs,
  output logic [11:0] p1_buttons,
  output logic [11:0] p2_buttons,
  output logic        p1_connected,
  output logic        p2_connected,
  output logic        frame_done
);
  localparam int HALF   = FREQ / (2 * SCK_HZ);
  localparam int TICK_N = FREQ / POLL_HZ;
  localparam int HW     = $clog2(HALF + 1);
  localparam int TW     = $clog2(TICK_N + 1);
`ifdef DS2_PORT2_EN
  localparam int   NPORTS    = 2;
  localparam logic LAST_PORT = 1'b1;
`else
  localparam int   NPORTS    = 1;
  localparam logic LAST_PORT = 1'b0;
`endif

  state_t        state, state_n;
  logic          port, port_n;
  logic [2:0]    byte_idx, byte_n;
  logic [1:0]    cnt, cnt_n;
  logic [HW-1:0] hcnt;
  logic [TW-1:0] tcnt;
  logic          hp, tick, start, fin, done;
  logic [7:0]    rx;
  logic [3:0]    id_hi;
  logic [7:0]    b0_r, b1_r;
  logic          miso_m, miso_s;
  logic          cs0, sel_n, valid;

  // free-running poll tick
  assign tick = (tcnt == TW'(TICK_N - 1));
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn)   tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // half-period divider restarts at every SEL entry so the frame grid
  // begins exactly where the select line falls
  assign hp = (state != IDLE) && (state != NEXT) && (hcnt == HW'(HALF - 1));
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn)                                   hcnt <= '0;
    else if (state == IDLE || state == NEXT || hp) hcnt <= '0;
    else                                           hcnt <= hcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      miso_m <= 1'b1;
      miso_s <= 1'b1;
    end else begin
      miso_m <= ds_miso;
      miso_s <= miso_m;
    end
  end

  ds2_spi_byte u_byte (
    .clk   (clk),
    .rst_n (I_RSTn),
    .hp    (hp),
    .start (start),
    .tx    (tx_byte(byte_idx)),
    .miso  (miso_s),
    .sck   (ds_clk),
    .mosi  (ds_mosi),
    .done  (done),
    .rx    (rx)
  );

  always_comb begin
    state_n = state;
    port_n  = port;
    byte_n  = byte_idx;
    cnt_n   = cnt;
    start   = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: if (tick) begin
        state_n = SEL;
        port_n  = 1'b0;
        byte_n  = 3'd0;
        cnt_n   = 2'd0;
      end
      SEL: if (hp) begin
        if (cnt == 2'd1) begin
          state_n = XFER;
          start   = 1'b1;
        end else cnt_n = cnt + 2'd1;
      end
      XFER: if (done) begin
        cnt_n = 2'd0;
        if (byte_idx == 3'd4) state_n = DESEL;
        else begin
          state_n = GAP;
          byte_n  = byte_idx + 3'd1;
        end
      end
      GAP: if (hp) begin
        if (cnt == 2'd3) begin
          state_n = XFER;
          start   = 1'b1;
        end else cnt_n = cnt + 2'd1;
      end
      DESEL: if (hp) begin
        if (cnt == 2'd3) begin
          state_n = NEXT;
          fin     = 1'b1;
        end else cnt_n = cnt + 2'd1;
      end
      NEXT: if (port != LAST_PORT) begin
        state_n = SEL;
        port_n  = 1'b1;
        byte_n  = 3'd0;
        cnt_n   = 2'd0;
      end else state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign sel_n = (state_n == SEL) || (state_n == XFER) || (state_n == GAP);

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state      <= IDLE;
      port       <= 1'b0;
      byte_idx   <= 3'd0;
      cnt        <= 2'd0;
      cs0        <= 1'b1;
      frame_done <= 1'b0;
      id_hi      <= 4'h0;
      b0_r       <= 8'hFF;
      b1_r       <= 8'hFF;
    end else begin
      state      <= state_n;
      port       <= port_n;
      byte_idx   <= byte_n;
      cnt        <= cnt_n;
      cs0        <= !(sel_n && !port_n);
      frame_done <= fin;
      if (state == XFER && done) begin
        case (byte_idx)
          3'd1:    id_hi <= rx[7:4];
          3'd3:    b0_r  <= rx;
          3'd4:    b1_r  <= rx;
          default: ;
        endcase
      end
    end
  end

  assign valid = (id_hi == ID_DIGITAL) || (id_hi == ID_ANALOG);

  // per-port latch: whole word updates on the frame_done edge; two
  // consecutive bad frames drop the pad
  for (genvar gp = 0; gp < NPORTS; gp++) begin : g_port
    logic [11:0] btn;
    logic        conn;
    logic [1:0]  miss;
    always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
        btn  <= 12'h000;
        conn <= 1'b0;
        miss <= 2'd0;
      end else if (fin && port == 1'(gp)) begin
        if (valid) begin
          btn  <= map_buttons(b0_r, b1_r);
          conn <= 1'b1;
          miss <= 2'd0;
        end else if (miss != 2'd0) begin
          btn  <= 12'h000;
          conn <= 1'b0;
          miss <= 2'd2;
        end else miss <= 2'd1;
      end
    end
  end

  assign p1_buttons   = g_port[0].btn;
  assign p1_connected = g_port[0].conn;
`ifdef DS2_PORT2_EN
  logic cs1;
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) cs1 <= 1'b1;
    else         cs1 <= !(sel_n && port_n);
  end
  assign ds_cs        = {cs1, cs0};
  assign p2_buttons   = g_port[1].btn;
  assign p2_connected = g_port[1].conn;
`else
  assign ds_cs        = {1'b1, cs0};
  assign p2_buttons   = 12'h000;
  assign p2_connected = 1'b0;
`endif

endmodule

// File: tb/tb_ds2_poll_scheduler.sv
// tb_ds2_poll_scheduler: pad model + bus monitor + frame-level reference model.
// Port 2 scenarios are built only with DS2_PORT2_EN.
module tb_ds2_poll_scheduler;
`ifdef DS2_PORT2_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic        clk = 1'b0;
  logic        I_RSTn = 1'b0;
  logic        ds_clk, ds_mosi;
  logic        ds_miso = 1'b1;
  logic [1:0]  ds_cs;
  logic [11:0] p1_buttons, p2_buttons;
  logic        p1_connected, p2_connected, frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ds2_poll_scheduler #(.FREQ(4_000_000), .SCK_HZ(500_000), .POLL_HZ(1000)) dut (
    .clk(clk), .I_RSTn(I_RSTn), .ds_clk(ds_clk), .ds_mosi(ds_mosi), .ds_miso(ds_miso),
    .ds_cs(ds_cs), .p1_buttons(p1_buttons), .p2_buttons(p2_buttons),
    .p1_connected(p1_connected), .p2_connected(p2_connected), .frame_done(frame_done)
  );

  // ---------------- pad model and bus monitor ----------------
  logic [7:0] resp [2][5];
  int pbyte = 0, pbit = 0, psel = 0;
  int mon_byte = 0, mon_bit = 0;
  logic [7:0] mon_sh = 8'h00;
  logic [7:0] cur, expb;
  time t_fall = 0;
  bit seen_p1 = 0;

  always @(negedge ds_cs[0] or negedge ds_cs[1]) begin
    pbyte = 0; pbit = 0; mon_byte = 0; mon_bit = 0;
  end

  always @(negedge ds_cs[0]) seen_p1 = 1;
  always @(negedge ds_cs[1]) begin
    tests++;
    if (!seen_p1) begin fails++; $display("FAIL cs_order: port 2 selected before port 1"); end
    seen_p1 = 0;
  end

  always @(posedge ds_cs[0] or posedge ds_cs[1]) begin
    ds_miso = 1'b1;
    if (I_RSTn) begin
      tests++;
      if (mon_byte != 5 || mon_bit != 0) begin
        fails++; $display("FAIL frame_len: bytes=%0d bits=%0d, want 5/0", mon_byte, mon_bit);
      end
    end
  end

  always @(negedge ds_clk) begin
    if (I_RSTn && ds_cs != 2'b11) begin
      t_fall = $time;
      psel = ds_cs[0] ? 1 : 0;
      if (pbyte < 5) begin cur = resp[psel][pbyte]; ds_miso = cur[pbit]; end
      else ds_miso = 1'b1;
      pbit++;
      if (pbit == 8) begin pbit = 0; pbyte++; end
    end
  end

  always @(posedge ds_clk) begin
    if (I_RSTn && ds_cs != 2'b11) begin
      tests++;
      if ($time - t_fall != 40) begin
        fails++; $display("FAIL sck_low_width: %0t, want 40", $time - t_fall);
      end
      mon_sh = {ds_mosi, mon_sh[7:1]};
      mon_bit++;
      if (mon_bit == 8) begin
        mon_bit = 0;
        expb = (mon_byte == 0) ? 8'h01 : (mon_byte == 1) ? 8'h42 : 8'h00;
        tests++;
        if (mon_sh !== expb) begin
          fails++; $display("FAIL mosi_byte%0d: got %02h want %02h", mon_byte, mon_sh, expb);
        end
        mon_byte++;
      end
    end
  end

  always @(negedge clk) begin
    if (I_RSTn) begin
      tests++;
      if (ds_cs === 2'b00) begin fails++; $display("FAIL cs_both_low: ds_cs=%b", ds_cs); end
`ifndef DS2_PORT2_EN
      tests++;
      if (ds_cs[1] !== 1'b1) begin fails++; $display("FAIL cs1_tied: ds_cs[1]=%b want 1", ds_cs[1]); end
`endif
    end
  end

  // ---------------- reference model ----------------
  logic [11:0] exp_btn  [2];
  logic        exp_conn [2];
  int          exp_miss [2];

  function automatic logic [11:0] ref_map(input logic [7:0] b0, input logic [7:0] b1);
    logic r, l, x, a, rt, lt, dn, up, st, se, y, b;
    r  = !b1[3] || !b1[1];  l  = !b1[2] || !b1[0];
    x  = !b1[4];  a  = !b1[5];  y  = !b1[7];  b  = !b1[6];
    rt = !b0[5];  lt = !b0[7];  dn = !b0[6];  up = !b0[4];
    st = !b0[3];  se = !b0[0];
    return {r, l, x, a, rt, lt, dn, up, st, se, y, b};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin exp_btn[p] = 12'h000; exp_conn[p] = 1'b0; exp_miss[p] = 0; end
  endtask

  task automatic model_apply(input int p);
    logic [7:0] id;
    id = resp[p][1];
    if (id[7:4] == 4'h4 || id[7:4] == 4'h7) begin
      exp_btn[p] = ref_map(resp[p][3], resp[p][4]); exp_conn[p] = 1'b1; exp_miss[p] = 0;
    end else begin
      exp_miss[p] = (exp_miss[p] + 1 > 2) ? 2 : exp_miss[p] + 1;
      if (exp_miss[p] == 2) begin exp_btn[p] = 12'h000; exp_conn[p] = 1'b0; end
    end
  endtask

  task automatic set_pad(input int p, input logic [7:0] id, input logic [7:0] b0, input logic [7:0] b1);
    resp[p][0] = 8'hFF; resp[p][1] = id; resp[p][2] = 8'h5A; resp[p][3] = b0; resp[p][4] = b1;
  endtask

  task automatic rand_pad(input int p);
    logic [7:0] id;
    case ($urandom_range(0, 3))
      0: id = 8'h41;
      1: id = 8'h73;
      2: id = 8'h12;
      default: id = 8'hFF;
    endcase
    set_pad(p, id, 8'($urandom), 8'($urandom));
  endtask

  // one round: NP frames, each checked against the model on its frame_done cycle
  task automatic run_round();
    bit got;
    logic [11:0] ob;
    logic oc;
    for (int f = 0; f < NP; f++) begin
      got = 0;
      for (int i = 0; i < 6000; i++) begin
        @(negedge clk);
        if (frame_done) begin got = 1; break; end
      end
      tests++;
      if (!got) begin fails++; $display("FAIL frame_done_timeout: frame %0d never ended", f); return; end
      model_apply(f);
      ob = (f == 0) ? p1_buttons : p2_buttons;
      oc = (f == 0) ? p1_connected : p2_connected;
      tests++;
      if (ob !== exp_btn[f]) begin fails++; $display("FAIL buttons_p%0d: got %03h want %03h", f + 1, ob, exp_btn[f]); end
      tests++;
      if (oc !== exp_conn[f]) begin fails++; $display("FAIL connected_p%0d: got %b want %b", f + 1, oc, exp_conn[f]); end
      @(negedge clk);
      tests++;
      if (frame_done !== 1'b0) begin fails++; $display("FAIL frame_done_pulse: got %b want 0", frame_done); end
`ifndef DS2_PORT2_EN
      tests++;
      if (p2_buttons !== 12'h000 || p2_connected !== 1'b0) begin
        fails++; $display("FAIL p2_tied: got %03h/%b want 000/0", p2_buttons, p2_connected);
      end
`endif
    end
  endtask

  task automatic wait_round_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (ds_cs !== 2'b11) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL round_start_timeout: ds_cs stayed %b", ds_cs); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    set_pad(0, 8'h41, 8'hEF, 8'hBF);
    set_pad(1, 8'h73, 8'hFE, 8'h7F);
    repeat (3) @(negedge clk);
    tests++;
    if ({ds_cs, ds_clk, ds_mosi, frame_done} !== 5'b11110) begin
      fails++; $display("FAIL reset_bus: cs/clk/mosi/fd=%b want 11110", {ds_cs, ds_clk, ds_mosi, frame_done});
    end
    tests++;
    if ({p1_buttons, p2_buttons, p1_connected, p2_connected} !== 26'd0) begin
      fails++; $display("FAIL reset_outputs: %03h %03h %b %b want all 0", p1_buttons, p2_buttons, p1_connected, p2_connected);
    end
    I_RSTn = 1'b1;
    repeat (200) @(negedge clk);
    tests++;
    if (ds_cs !== 2'b11) begin fails++; $display("FAIL idle_before_tick: ds_cs=%b want 11", ds_cs); end
  endtask

  task automatic test_known_pad();
    run_round();
    tests++;
    if (p1_buttons !== 12'h011) begin fails++; $display("FAIL known_pad: got %03h want 011", p1_buttons); end
    tests++;
    if (p1_connected !== 1'b1) begin fails++; $display("FAIL known_conn: got %b want 1", p1_connected); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < NP; p++) rand_pad(p);
      run_round();
    end
  endtask

  // valid frame with buttons pressed, then three bad frames on the last port
  task automatic test_miss();
    int tp;
    logic [11:0] ob;
    tp = NP - 1;
    for (int p = 0; p < NP; p++) set_pad(p, 8'h41, 8'h00, 8'h00);
    run_round();
    set_pad(tp, 8'hFF, 8'hFF, 8'hFF);
    for (int r = 0; r < 3; r++) begin
      run_round();
      ob = (tp == 0) ? p1_buttons : p2_buttons;
      tests++;
      if (r == 0 && ob !== 12'hFFF) begin fails++; $display("FAIL miss_hold: got %03h want fff", ob); end
      else if (r > 0 && ob !== 12'h000) begin fails++; $display("FAIL miss_clear: got %03h want 000", ob); end
    end
  endtask

  task automatic test_mid_tick();
    bit ok;
    int n;
    for (int p = 0; p < NP; p++) set_pad(p, 8'h73, 8'h5A, 8'hA5);
    wait_round_start(ok);
    if (!ok) return;
    repeat (100) @(negedge clk);
    force dut.tick = 1'b1;
    @(negedge clk);
    release dut.tick;
    n = 0;
    for (int i = 0; i < 2800; i++) begin
      @(negedge clk);
      if (frame_done) n++;
    end
    tests++;
    if (n != NP) begin fails++; $display("FAIL mid_tick_frames: got %0d want %0d", n, NP); end
    for (int p = 0; p < NP; p++) model_apply(p);
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int p = 0; p < NP; p++) set_pad(p, 8'h41, 8'h0F, 8'hF0);
    wait_round_start(ok);
    if (!ok) return;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (mon_byte == 3 && ds_cs == 2'b10) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL byte3_timeout: mon_byte=%0d", mon_byte); return; end
    repeat (10) @(negedge clk);
    #2 I_RSTn = 1'b0;
    #1;
    tests++;
    if (ds_cs !== 2'b11 || ds_clk !== 1'b1) begin
      fails++; $display("FAIL reset_abort_bus: cs=%b clk=%b want 11/1", ds_cs, ds_clk);
    end
    tests++;
    if ({p1_buttons, p1_connected, p2_buttons, p2_connected, frame_done} !== 27'd0) begin
      fails++; $display("FAIL reset_abort_out: %03h %b %03h %b %b want 0", p1_buttons, p1_connected, p2_buttons, p2_connected, frame_done);
    end
    model_reset();
    repeat (3) @(negedge clk);
    I_RSTn = 1'b1;
    wait_round_start(ok);
    if (!ok) return;
    tests++;
    if (ds_cs !== 2'b10) begin fails++; $display("FAIL restart_port1: ds_cs=%b want 10", ds_cs); end
    run_round();
  endtask

  initial begin
    test_reset();
    test_known_pad();
    test_random();
    test_miss();
    test_mid_tick();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
